// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: writeback arbiter for the FP register file.
//
// Merges three result producers onto the two register-file write ports:
//   - FPU pipe (fixed latency, no backpressure) always owns port 1 when valid.
//   - LSU load returns and DIV/SQRT results (valid/ready) are buffered in
//     per-source FIFOs and issued onto whichever ports are free.
// Same-cycle writes to one address are never issued: a FIFO head whose
// address matches the concurrent FPU result is held back a cycle.
//
// Parameters:
//   DATA_W      FP register width
//   FIFO_DEPTH  entries per buffered source (power of two, >= 2)
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   fpu_valid/fpu_addr/fpu_data         FPU result (no stall)
//   lsu_valid/lsu_ready/lsu_addr/lsu_data  load return handshake
//   div_valid/div_ready/div_addr/div_data  div/sqrt handshake
//   we0/waddr0/wdata0, we1/waddr1/wdata1   registered register-file writes
//   wb_done_mask                        per-register write strobe, aligned
//                                       with we0/we1; present only when
//                                       FP_WB_DONE_MASK_EN is defined

module fp_wb_arbiter_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [4:0]        push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              ready,
    output logic              not_empty,
    output logic [4:0]        head_addr,
    output logic [DATA_W-1:0] head_data
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [4:0]        mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Ready depends only on the registered count.
    assign ready     = (count < FULL);
    assign not_empty = (count != '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module fp_wb_arbiter #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fpu_valid,
    input  logic [4:0]        fpu_addr,
    input  logic [DATA_W-1:0] fpu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [4:0]        lsu_addr,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [4:0]        div_addr,
    input  logic [DATA_W-1:0] div_data,
    output logic              we0,
    output logic [4:0]        waddr0,
    output logic [DATA_W-1:0] wdata0,
    output logic              we1,
    output logic [4:0]        waddr1,
    output logic [DATA_W-1:0] wdata1
`ifdef FP_WB_DONE_MASK_EN
    ,
    output logic [31:0]       wb_done_mask
`endif
);
    typedef enum logic {RR_LSU, RR_DIV} rr_t;

    rr_t               rr_q, rr_d;
    logic              lsu_ne, div_ne, lsu_pop, div_pop;
    logic [4:0]        lsu_haddr, div_haddr;
    logic [DATA_W-1:0] lsu_hdata, div_hdata;
    logic              lsu_elig, div_elig;
    logic              g0_lsu, g0_div, g1_div;
    logic              we0_d, we1_d;
    logic [4:0]        waddr0_d, waddr1_d;
    logic [DATA_W-1:0] wdata0_d, wdata1_d;

    fp_wb_arbiter_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lsu_valid && lsu_ready),
        .push_addr (lsu_addr),
        .push_data (lsu_data),
        .pop       (lsu_pop),
        .ready     (lsu_ready),
        .not_empty (lsu_ne),
        .head_addr (lsu_haddr),
        .head_data (lsu_hdata)
    );

    fp_wb_arbiter_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_div_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (div_valid && div_ready),
        .push_addr (div_addr),
        .push_data (div_data),
        .pop       (div_pop),
        .ready     (div_ready),
        .not_empty (div_ne),
        .head_addr (div_haddr),
        .head_data (div_hdata)
    );

    // A head colliding with the concurrent FPU write is deferred, which also
    // guarantees port 0 never matches the FPU's port-1 address.
    assign lsu_elig = lsu_ne && !(fpu_valid && (lsu_haddr == fpu_addr));
    assign div_elig = div_ne && !(fpu_valid && (div_haddr == fpu_addr));

    always_comb begin
        g0_lsu = 1'b0;
        g0_div = 1'b0;
        g1_div = 1'b0;
        rr_d   = rr_q;
        if (lsu_elig && div_elig) begin
            if (!fpu_valid && (lsu_haddr != div_haddr)) begin
                g0_lsu = 1'b1;
                g1_div = 1'b1;
            end else if (rr_q == RR_LSU) begin
                g0_lsu = 1'b1;
                rr_d   = RR_DIV;
            end else begin
                g0_div = 1'b1;
                rr_d   = RR_LSU;
            end
        end else if (lsu_elig) begin
            g0_lsu = 1'b1;
        end else if (div_elig) begin
            g0_div = 1'b1;
        end
    end

    assign lsu_pop = g0_lsu;
    assign div_pop = g0_div || g1_div;

    always_comb begin
        we0_d    = g0_lsu || g0_div;
        waddr0_d = '0;
        wdata0_d = '0;
        if (g0_lsu) begin
            waddr0_d = lsu_haddr;
            wdata0_d = lsu_hdata;
        end else if (g0_div) begin
            waddr0_d = div_haddr;
            wdata0_d = div_hdata;
        end
        we1_d    = fpu_valid || g1_div;
        waddr1_d = '0;
        wdata1_d = '0;
        if (fpu_valid) begin
            waddr1_d = fpu_addr;
            wdata1_d = fpu_data;
        end else if (g1_div) begin
            waddr1_d = div_haddr;
            wdata1_d = div_hdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q   <= RR_LSU;
            we0    <= 1'b0;
            waddr0 <= '0;
            wdata0 <= '0;
            we1    <= 1'b0;
            waddr1 <= '0;
            wdata1 <= '0;
        end else begin
            rr_q   <= rr_d;
            we0    <= we0_d;
            waddr0 <= waddr0_d;
            wdata0 <= wdata0_d;
            we1    <= we1_d;
            waddr1 <= waddr1_d;
            wdata1 <= wdata1_d;
        end
    end

`ifdef FP_WB_DONE_MASK_EN
    logic [31:0] mask_d;

    always_comb begin
        mask_d = '0;
        if (we0_d) mask_d[waddr0_d] = 1'b1;
        if (we1_d) mask_d[waddr1_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wb_done_mask <= '0;
        else        wb_done_mask <= mask_d;
    end
`endif
endmodule

// File: tb/tb_fp_wb_arbiter.sv
module tb_fp_wb_arbiter;
    localparam int unsigned DW = 16;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fpu_valid = 1'b0, lsu_valid = 1'b0, div_valid = 1'b0;
    logic [4:0]    fpu_addr = '0, lsu_addr = '0, div_addr = '0;
    logic [DW-1:0] fpu_data = '0, lsu_data = '0, div_data = '0;
    logic          lsu_ready, div_ready, we0, we1;
    logic [4:0]    waddr0, waddr1;
    logic [DW-1:0] wdata0, wdata1;
`ifdef FP_WB_DONE_MASK_EN
    logic [31:0]   wb_done_mask;
`endif

    fp_wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fpu_valid(fpu_valid), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .div_valid(div_valid), .div_ready(div_ready), .div_addr(div_addr), .div_data(div_data),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
`ifdef FP_WB_DONE_MASK_EN
        , .wb_done_mask(wb_done_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } ent_t;

    wr_t  exp0[$], exp1[$];   // scoreboard: expected writes per port
    ent_t lq[$], dq[$];       // reference contents of the source buffers
    bit   rr_div = 1'b0;      // reference round-robin: 0 = LSU preferred
    int unsigned cyc = 0;
    int checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares each cycle's registered write ports with the scoreboard.
    initial begin
        wr_t e;
        bit  x0, x1;
        logic [31:0] mask;
        forever begin
            @(posedge clk);
            #1;
            mask = '0;
            x0 = (exp0.size() > 0) && (exp0[0].cyc == cyc);
            x1 = (exp1.size() > 0) && (exp1[0].cyc == cyc);
            chk("we0", we0, x0);
            chk("we1", we1, x1);
            if (x0) begin
                e = exp0.pop_front();
                mask[e.addr] = 1'b1;
                if (we0) begin
                    chk("waddr0", waddr0, e.addr);
                    chk("wdata0", wdata0, e.data);
                end
            end
            if (x1) begin
                e = exp1.pop_front();
                mask[e.addr] = 1'b1;
                if (we1) begin
                    chk("waddr1", waddr1, e.addr);
                    chk("wdata1", wdata1, e.data);
                end
            end
            if (we0 && we1) chk("same_addr_dual_write", waddr0 == waddr1, 1'b0);
`ifdef FP_WB_DONE_MASK_EN
            chk("wb_done_mask", wb_done_mask, mask);
`endif
        end
    end

    // Reference model: decides from the arbitration rules what the coming
    // edge does, then records the resulting writes and buffer changes.
    task automatic model_edge();
        bit le, de, g0l = 0, g0d = 0, g1d = 0;
        bit lr, dr;
        lr = lq.size() < DEPTH;
        dr = dq.size() < DEPTH;
        le = (lq.size() > 0) && !(fpu_valid && lq[0].addr == fpu_addr);
        de = (dq.size() > 0) && !(fpu_valid && dq[0].addr == fpu_addr);
        if (le && de) begin
            if (!fpu_valid && lq[0].addr != dq[0].addr) begin g0l = 1; g1d = 1; end
            else if (!rr_div) begin g0l = 1; rr_div = 1; end
            else begin g0d = 1; rr_div = 0; end
        end else if (le) g0l = 1;
        else if (de) g0d = 1;

        if (g0l) exp0.push_back('{cyc + 1, lq[0].addr, lq[0].data});
        if (g0d) exp0.push_back('{cyc + 1, dq[0].addr, dq[0].data});
        if (fpu_valid) exp1.push_back('{cyc + 1, fpu_addr, fpu_data});
        else if (g1d) exp1.push_back('{cyc + 1, dq[0].addr, dq[0].data});
        if (g0l) void'(lq.pop_front());
        if (g0d || g1d) void'(dq.pop_front());
        if (lsu_valid && lr) lq.push_back('{lsu_addr, lsu_data});
        if (div_valid && dr) dq.push_back('{div_addr, div_data});
    endtask

    // One cycle of stimulus; a source stalled by ready=0 keeps its request.
    task automatic step(input bit fv, input logic [4:0] fa, input logic [DW-1:0] fd,
                        input bit lv, input logic [4:0] la, input logic [DW-1:0] ld,
                        input bit dv, input logic [4:0] da, input logic [DW-1:0] dd);
        @(negedge clk);
        chk("lsu_ready", lsu_ready, lq.size() < DEPTH);
        chk("div_ready", div_ready, dq.size() < DEPTH);
        rst_n = 1'b1;
        fpu_valid = fv; fpu_addr = fa; fpu_data = fd;
        if (!(lsu_valid && lq.size() >= DEPTH)) begin
            lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        end
        if (!(div_valid && dq.size() >= DEPTH)) begin
            div_valid = dv; div_addr = da; div_data = dd;
        end
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fpu_valid = 0; lsu_valid = 0; div_valid = 0;
        lq.delete(); dq.delete(); rr_div = 0;
        @(negedge clk);
        chk("rst_we0", we0, 1'b0);
        chk("rst_we1", we1, 1'b0);
        chk("rst_waddr0", waddr0, 5'd0);
        chk("rst_wdata0", wdata0, 16'd0);
        chk("rst_waddr1", waddr1, 5'd0);
        chk("rst_wdata1", wdata1, 16'd0);
        chk("rst_lsu_ready", lsu_ready, 1'b1);
        chk("rst_div_ready", div_ready, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        // FPU alone, then a dual LSU+DIV write with an idle FPU.
        step(1, 5, 16'h3C00, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 3, 16'h1111, 1, 7, 16'h7777);
        idle(3);

        // Address collision: both heads at 9, FPU writing 9, then released.
        step(0, 0, 0, 1, 9, 16'hAAAA, 1, 9, 16'hBBBB);
        step(1, 9, 16'h9999, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Contention: FPU busy every cycle while both sources push.
        for (int i = 0; i < 8; i++)
            step(1, 5'(20 + i), 16'($urandom), 1, 5'(i), 16'($urandom),
                 1, 5'(10 + i), 16'($urandom));
        for (int i = 0; i < 6; i++) step(1, 5'(28 + i % 4), 16'($urandom), 0, 0, 0, 0, 0, 0);
        idle(3);

        // Fill both FIFOs behind a colliding FPU stream, then reset mid-flight.
        for (int i = 0; i < 4; i++)
            step(1, 9, 16'($urandom), 1, 9, 16'($urandom), 1, 9, 16'($urandom));
        do_reset();
        idle(4);

        // Randomised traffic over a small address range to provoke collisions.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), 16'($urandom));
        idle(8);
        @(negedge clk);
        chk("drain_exp0_empty", exp0.size(), 0);
        chk("drain_exp1_empty", exp1.size(), 0);
        chk("drain_lsu_ready", lsu_ready, 1'b1);
        chk("drain_div_ready", div_ready, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
